// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the fetch port (i, read-only)
// and the load/store port (d). One transaction at a time: issue, wait RD_LAT, ack.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises req with its fields stable and keeps it up until
  // its one-cycle ack; fields are sampled only in IDLE, and req must be low in the
  // cycle after ack unless a new request is being presented.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic [1:0]        cnt;
  logic              last_d;
  logic              gnt_d;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              pick_d;
  logic              take;

  always_comb begin
    take     = i_req | d_req;
    // On a tie the port that did not win last time gets the RAM.
    pick_d   = d_req & (~i_req | ~last_d);
    state_nx = state;
    case (state)
      S_IDLE:  if (take) state_nx = S_ISSUE;
      S_ISSUE: state_nx = lat_we ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 2'd0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (take) begin
            gnt_d     <= pick_d;
            lat_addr  <= pick_d ? d_addr : i_addr;
            lat_we    <= pick_d & d_we;
            lat_wdata <= pick_d ? d_wdata : '0;
          end
        end
        S_ISSUE: begin
          if (!lat_we) cnt <= LAT_INIT;
        end
        S_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else if (gnt_d) begin
            d_rdata <= mem_rdata;
          end else begin
            i_rdata <= mem_rdata;
          end
        end
        S_DONE: last_d <= gnt_d;
        default: ;
      endcase
    end
  end

  // RAM strobes are decoded from state so nothing reaches them combinationally from req.
  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;
  assign i_ack     = (state == S_DONE) & ~gnt_d;
  assign d_ack     = (state == S_DONE) & gnt_d;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and arbitrates the single-port synchronous RAM between the instruction-fetch requester (port `i`, read-only) and the load/store requester (port `d`, read/write). It takes one request at a time, drives the RAM for one issue cycle, waits the RAM read latency, then returns a one-cycle acknowledge with the read data to the winner. It sits between the IF/MEM stage logic and the RAM, and replaces direct RAM enables from the stage controller.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `RD_LAT`, 2, RAM read latency in cycles (legal 1..4)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_ack`  out  1  one-cycle fetch completion pulse
- `i_rdata`  out  DATA_W  fetch data, valid with `i_ack`, held until next fetch completes
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_W  load data, valid with `d_ack` on reads, held otherwise
- `mem_en`  out  1  RAM enable
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid RD_LAT cycles after the `mem_en` cycle
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if no request, stay. If exactly one pending, grant it. If both pending, grant the port not granted last (`last_grant` register; reset value = fetch, so data wins the first tie). Latch port id, addr, we (forced 0 for fetch), wdata; go ISSUE.
- ISSUE: `mem_en`=1, `mem_we`=latched we, `mem_addr`/`mem_wdata`=latched values. Write → DONE. Read → WAIT with latency counter loaded to RD_LAT-1.
- WAIT: `mem_en`=0. Decrement counter; the cycle in which counter = 0 is the cycle `mem_rdata` is valid; capture it into the granted port's rdata register and go DONE.
- DONE: pulse ack of granted port for exactly one cycle; update `last_grant`; go IDLE.
- Inputs are sampled only in IDLE; changes to addr/wdata/we/req during a transaction are ignored. A requester dropping req mid-transaction does not abort it; ack still issues.
- Requester must have req low in the cycle after its ack unless presenting a new request; a high req in IDLE is always a new request.
- Ungranted port's rdata register is never modified.
- Reset: state IDLE, counter 0, `last_grant`=fetch, all outputs 0 (`i_rdata`, `d_rdata` = 0). Reset during ISSUE does not suppress the RAM access already driven that cycle (a write commits); no ack is ever issued for an aborted transaction.

## Timing
- Request seen in IDLE at cycle T: ISSUE at T+1.
- Read: `mem_rdata` captured at end of cycle T+1+RD_LAT; ack and rdata visible at T+2+RD_LAT; IDLE again at T+3+RD_LAT. Read period RD_LAT+3 cycles.
- Write: ack at T+2; IDLE at T+3. Write period 3 cycles.
- `mem_en` high for exactly one cycle per transaction; never high in IDLE, WAIT or DONE.
- All outputs registered or decoded from registered state; no combinational path from any req/addr input to any output.
- Arbitration decision has zero-cycle bias only at ties; a lone requester is granted in the first IDLE cycle it is seen.

## Test plan
- Reset: assert `reset` 3 cycles with `i_req`=`d_req`=1 → all outputs 0, `mem_en` never high; after release, first ISSUE is the data port.
- Fetch read, RD_LAT=2: `i_req`, `i_addr`=0x100 at T; RAM model returns 0xDEADBEEF → `mem_en`=1, `mem_we`=0, `mem_addr`=0x100 at T+1 only; `i_ack`=1 with `i_rdata`=0xDEADBEEF at T+4 for one cycle; `d_ack` stays 0.
- Data write: `d_req`, `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678 at T → `mem_en`=`mem_we`=1 with those values at T+1; `d_ack` at T+2; `d_rdata` unchanged.
- Contention: both req held continuously, fresh addresses after each ack → grants alternate d, i, d, i; neither port is acked twice in a row.
- Back-to-back fetch reads, RD_LAT=1 and RD_LAT=4 → `i_ack` period 4 and 7 cycles respectively; each `i_rdata` matches the RAM word at its address.
- Reset mid-read: assert `reset` during WAIT → next cycle IDLE, `busy`=0, no ack emitted; subsequent request completes normally.
